// File: rtl/legv8_decode_exec_mem.sv
// Single-cycle LEGv8-subset decode, ALU and 64-word data memory.
// Decode, ALU, memory read and write-back are combinational; only stores are clocked.
module legv8_decode_exec_mem (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  output logic        reg2loc,
  output logic        uncondbranch,
  output logic        branch,
  output logic        memread,
  output logic        memtoreg,
  output logic        memwrite,
  output logic        alusrc,
  output logic        regwrite,
  output logic [3:0]  alu_control,
  output logic [4:0]  read_reg1,
  output logic [4:0]  read_reg2,
  output logic [4:0]  write_reg,
  output logic [31:0] imm,
  output logic [3:0]  inst_id,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_rdata,
  output logic [31:0] write_back
);

  localparam logic [3:0] ID_UNK  = 4'd0,  ID_ADD  = 4'd1, ID_SUB  = 4'd2, ID_AND  = 4'd3,
                         ID_ORR  = 4'd4,  ID_ADDI = 4'd5, ID_SUBI = 4'd6, ID_LDUR = 4'd7,
                         ID_STUR = 4'd8,  ID_CBZ  = 4'd9, ID_B    = 4'd10;

  logic [7:0]  ctrl;
  logic [31:0] alu_b;
  logic [5:0]  mem_idx;
  logic [31:0] mem_q [64];

  // Widest opcode wins, so shorter opcodes only apply when no longer one matched.
  always_comb begin
    inst_id = ID_UNK;
    case (instruction[31:21])
      11'b10001011000: inst_id = ID_ADD;
      11'b11001011000: inst_id = ID_SUB;
      11'b10001010000: inst_id = ID_AND;
      11'b10101010000: inst_id = ID_ORR;
      11'b11111000010: inst_id = ID_LDUR;
      11'b11111000000: inst_id = ID_STUR;
      default: begin
        if      (instruction[31:22] == 10'b1001000100) inst_id = ID_ADDI;
        else if (instruction[31:22] == 10'b1101000100) inst_id = ID_SUBI;
        else if (instruction[31:24] == 8'b10110100)    inst_id = ID_CBZ;
        else if (instruction[31:26] == 6'b000101)      inst_id = ID_B;
      end
    endcase
  end

  always_comb begin
    ctrl        = 8'b0000_0000;
    alu_control = 4'b0010;
    imm         = 32'd0;
    case (inst_id)
      ID_ADD:  ctrl = 8'b0000_0001;
      ID_SUB:  begin ctrl = 8'b0000_0001; alu_control = 4'b0110; end
      ID_AND:  begin ctrl = 8'b0000_0001; alu_control = 4'b0000; end
      ID_ORR:  begin ctrl = 8'b0000_0001; alu_control = 4'b0001; end
      ID_ADDI: begin ctrl = 8'b0000_0011; imm = {20'd0, instruction[21:10]}; end
      ID_SUBI: begin
        ctrl = 8'b0000_0011; alu_control = 4'b0110; imm = {20'd0, instruction[21:10]};
      end
      ID_LDUR: begin ctrl = 8'b0001_1011; imm = {{23{instruction[20]}}, instruction[20:12]}; end
      ID_STUR: begin ctrl = 8'b1000_0110; imm = {{23{instruction[20]}}, instruction[20:12]}; end
      ID_CBZ:  begin
        ctrl = 8'b1010_0000; alu_control = 4'b0111;
        imm  = {{13{instruction[23]}}, instruction[23:5]};
      end
      ID_B:    begin ctrl = 8'b0100_0000; imm = {{6{instruction[25]}}, instruction[25:0]}; end
      default: ;
    endcase
  end

  assign {reg2loc, uncondbranch, branch, memread, memtoreg, memwrite, alusrc, regwrite} = ctrl;

  assign read_reg1 = instruction[9:5];
  assign read_reg2 = reg2loc ? instruction[4:0] : instruction[20:16];
  assign write_reg = instruction[4:0];

  assign alu_b = alusrc ? imm : read_data2;

  always_comb begin
    case (alu_control)
      4'b0000: alu_result = read_data1 & alu_b;
      4'b0001: alu_result = read_data1 | alu_b;
      4'b0010: alu_result = read_data1 + alu_b;
      4'b0110: alu_result = read_data1 - alu_b;
      4'b0111: alu_result = alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // Byte offset and upper address bits are dropped: the 64 words alias across the space.
  assign mem_idx = alu_result[7:2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= 32'd0;
    end else if (memwrite) begin
      mem_q[mem_idx] <= read_data2;
    end
  end

  assign mem_rdata  = memread ? mem_q[mem_idx] : 32'd0;
  assign write_back = memtoreg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_legv8_decode_exec_mem.sv
// Directed-vector bench: stimulus queues expected values, a negedge monitor pops and compares.
module tb_legv8_decode_exec_mem;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction, read_data1, read_data2;
  logic        reg2loc, uncondbranch, branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [3:0]  alu_control, inst_id;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] imm, alu_result, mem_rdata, write_back;
  logic        zero;

  legv8_decode_exec_mem dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction),
    .read_data1(read_data1), .read_data2(read_data2),
    .reg2loc(reg2loc), .uncondbranch(uncondbranch), .branch(branch), .memread(memread),
    .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
    .alu_control(alu_control), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .imm(imm), .inst_id(inst_id), .alu_result(alu_result),
    .zero(zero), .mem_rdata(mem_rdata), .write_back(write_back)
  );

  always #5 clock = ~clock;

  typedef enum int {S_ALU, S_ZERO, S_CTRL, S_ALUC, S_RR1, S_RR2, S_WR, S_IMM, S_ID, S_MEM, S_WB} sel_t;
  typedef struct { string name; sel_t sel; logic [31:0] val; } chk_t;
  chk_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_v(input string name, input sel_t sel, input logic [31:0] val);
    chk_t c;
    c.name = name; c.sel = sel; c.val = val;
    q.push_back(c);
  endtask

  function automatic logic [31:0] observe(input sel_t sel);
    case (sel)
      S_ALU:  return alu_result;
      S_ZERO: return {31'd0, zero};
      S_CTRL: return {24'd0, reg2loc, uncondbranch, branch, memread, memtoreg, memwrite, alusrc, regwrite};
      S_ALUC: return {28'd0, alu_control};
      S_RR1:  return {27'd0, read_reg1};
      S_RR2:  return {27'd0, read_reg2};
      S_WR:   return {27'd0, write_reg};
      S_IMM:  return imm;
      S_ID:   return {28'd0, inst_id};
      S_MEM:  return mem_rdata;
      default: return write_back;
    endcase
  endfunction

  always @(negedge clock) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c   = q.pop_front();
      act = observe(c.sel);
      n_cmp++;
      if (act !== c.val) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.val);
      end
    end
  end

  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    instruction = ins; read_data1 = a; read_data2 = b;
  endtask

  initial begin
    reset_n = 1'b0; instruction = 32'd0; read_data1 = 32'd0; read_data2 = 32'd0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // reset state: load from cleared memory
    step(32'hF8410025, 32'd8, 32'd0);
    expect_v("rst_mem", S_MEM, 32'd0);
    expect_v("ldur_ctrl", S_CTRL, 32'h1B);
    expect_v("ldur_id", S_ID, 32'd7);
    expect_v("ldur_addr", S_ALU, 32'd24);

    step(32'h8B020023, 32'd5, 32'd7);
    expect_v("add_res", S_ALU, 32'd12);
    expect_v("add_zero", S_ZERO, 32'd0);
    expect_v("add_ctrl", S_CTRL, 32'h01);
    expect_v("add_rr1", S_RR1, 32'd1);
    expect_v("add_rr2", S_RR2, 32'd2);
    expect_v("add_wr", S_WR, 32'd3);
    expect_v("add_id", S_ID, 32'd1);
    expect_v("add_wb", S_WB, 32'd12);
    expect_v("add_aluc", S_ALUC, 32'h2);
    expect_v("add_imm", S_IMM, 32'd0);
    expect_v("add_mem", S_MEM, 32'd0);

    step(32'hCB020023, 32'd9, 32'd9);
    expect_v("sub_res", S_ALU, 32'd0);
    expect_v("sub_zero", S_ZERO, 32'd1);
    expect_v("sub_aluc", S_ALUC, 32'h6);
    expect_v("sub_id", S_ID, 32'd2);
    step(32'hCB020023, 32'd0, 32'd1);
    expect_v("sub_wrap", S_ALU, 32'hFFFFFFFF);
    expect_v("sub_wrap_zero", S_ZERO, 32'd0);

    step(32'h8A020023, 32'h0000F0F0, 32'h0000FF00);
    expect_v("and_res", S_ALU, 32'h0000F000);
    expect_v("and_aluc", S_ALUC, 32'h0);
    expect_v("and_id", S_ID, 32'd3);
    step(32'hAA020023, 32'h0000F0F0, 32'h0000FF00);
    expect_v("orr_res", S_ALU, 32'h0000FFF0);
    expect_v("orr_aluc", S_ALUC, 32'h1);
    expect_v("orr_id", S_ID, 32'd4);

    step(32'h913FFC23, 32'd1, 32'd99);
    expect_v("addi_imm", S_IMM, 32'h00000FFF);
    expect_v("addi_res", S_ALU, 32'h00001000);
    expect_v("addi_ctrl", S_CTRL, 32'h03);
    expect_v("addi_id", S_ID, 32'd5);
    step(32'hD1000423, 32'd10, 32'd99);
    expect_v("subi_res", S_ALU, 32'd9);
    expect_v("subi_aluc", S_ALUC, 32'h6);
    expect_v("subi_id", S_ID, 32'd6);

    // store then load the same word next cycle, and via an aliased address
    step(32'hF8010022, 32'd8, 32'hDEADBEEF);
    expect_v("stur_addr", S_ALU, 32'd24);
    expect_v("stur_ctrl", S_CTRL, 32'h86);
    expect_v("stur_rr2", S_RR2, 32'd2);
    expect_v("stur_imm", S_IMM, 32'd16);
    expect_v("stur_id", S_ID, 32'd8);
    expect_v("stur_mem", S_MEM, 32'd0);
    step(32'hF8410025, 32'd8, 32'd0);
    expect_v("ldur_data", S_MEM, 32'hDEADBEEF);
    expect_v("ldur_wb", S_WB, 32'hDEADBEEF);
    expect_v("ldur_wr", S_WR, 32'd5);
    step(32'hF8410025, 32'd8 + 32'd256 + 32'd2, 32'd0);
    expect_v("ldur_alias", S_MEM, 32'hDEADBEEF);

    step(32'hB4FFFFC4, 32'd77, 32'd0);
    expect_v("cbz_imm", S_IMM, 32'hFFFFFFFE);
    expect_v("cbz_ctrl", S_CTRL, 32'hA0);
    expect_v("cbz_rr2", S_RR2, 32'd4);
    expect_v("cbz_aluc", S_ALUC, 32'h7);
    expect_v("cbz_zero", S_ZERO, 32'd1);
    expect_v("cbz_id", S_ID, 32'd9);
    step(32'hB4FFFFC4, 32'd77, 32'd3);
    expect_v("cbz_nz", S_ZERO, 32'd0);
    expect_v("cbz_pass", S_ALU, 32'd3);

    step(32'h17FFFFFF, 32'd0, 32'd0);
    expect_v("b_ctrl", S_CTRL, 32'h40);
    expect_v("b_imm", S_IMM, 32'hFFFFFFFF);
    expect_v("b_id", S_ID, 32'd10);
    step(32'h00000000, 32'd4, 32'd4);
    expect_v("unk_ctrl", S_CTRL, 32'h00);
    expect_v("unk_imm", S_IMM, 32'd0);
    expect_v("unk_id", S_ID, 32'd0);
    expect_v("unk_aluc", S_ALUC, 32'h2);

    // mid-cycle reset pulse wipes a stored word
    step(32'hF8010022, 32'd8, 32'h00001234);
    step(32'hF8410025, 32'd8, 32'd0);
    expect_v("pre_rst_data", S_MEM, 32'h00001234);
    step(32'h00000000, 32'd0, 32'd0);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    step(32'hF8410025, 32'd8, 32'd0);
    expect_v("post_rst_data", S_MEM, 32'd0);

    // a write edge while reset is held must not land
    step(32'hF8010022, 32'd8, 32'h00005555);
    reset_n = 1'b0;
    expect_v("rst_comb_addr", S_ALU, 32'd24);
    step(32'hF8410025, 32'd8, 32'd0);
    reset_n = 1'b1;
    expect_v("rst_blocked_wr", S_MEM, 32'd0);

    repeat (2) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
